// File: rtl/sorter_pkg.sv
// rtl/sorter_pkg.sv - shared mode constants, FSM state encoding and mode decode for sorter_stream
// Contents:
//   M_QPSK / M_QAM16 / M_N8 / M_ILLEGAL : values of the 2-bit mode input
//   state_t                             : IDLE -> LOAD -> SORT -> DONE
//   mode_to_n()                         : sort length for a legal mode
package sorter_pkg;

    localparam logic [1:0] M_QPSK    = 2'b00;
    localparam logic [1:0] M_QAM16   = 2'b01;
    localparam logic [1:0] M_N8      = 2'b10;
    localparam logic [1:0] M_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SORT = 2'd2,
        DONE = 2'd3
    } state_t;

    // M_ILLEGAL never reaches a running sort, so it shares the QPSK length.
    function automatic int mode_to_n(input logic [1:0] mode);
        case (mode)
            M_QAM16: return 16;
            M_N8:    return 8;
            default: return 4;
        endcase
    endfunction

endpackage

// File: rtl/sorter_stream_if.sv
// rtl/sorter_stream_if.sv - metric input stream bundle for sorter_stream
// Signals:
//   in_valid : beat valid (master -> slave)
//   d_in     : LANES*WIDTH beat data, lane 0 in the lowest bits (master -> slave)
//   in_ready : slave accepts beats (slave -> master)
interface sorter_stream_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [LANES*WIDTH-1:0]   d_in;

    modport master (output in_valid, output d_in, input in_ready);
    modport slave  (input in_valid, input d_in, output in_ready);
endinterface

// File: rtl/sorter_cmp_swap.sv
// rtl/sorter_cmp_swap.sv - combinational compare-exchange of two {value, index} pairs
// Build option: SORTER_SIGNED_EN selects two's-complement comparison (unsigned otherwise).
// Ports:
//   en_i               : exchange allowed
//   a_val_i / a_idx_i  : element in the lower slot
//   b_val_i / b_idx_i  : element in the upper slot
//   lo_val_o / lo_idx_o: element for the lower slot
//   hi_val_o / hi_idx_o: element for the upper slot
module sorter_cmp_swap #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
) (
    input  logic             en_i,
    input  logic [WIDTH-1:0] a_val_i,
    input  logic [IDX_W-1:0] a_idx_i,
    input  logic [WIDTH-1:0] b_val_i,
    input  logic [IDX_W-1:0] b_idx_i,
    output logic [WIDTH-1:0] lo_val_o,
    output logic [IDX_W-1:0] lo_idx_o,
    output logic [WIDTH-1:0] hi_val_o,
    output logic [IDX_W-1:0] hi_idx_o
);
    logic less;
    logic swap;

`ifdef SORTER_SIGNED_EN
    assign less = $signed(b_val_i) < $signed(a_val_i);
`else
    assign less = b_val_i < a_val_i;
`endif

    // Strict compare: equal values never move, which keeps the sort stable.
    assign swap     = en_i && less;
    assign lo_val_o = swap ? b_val_i : a_val_i;
    assign lo_idx_o = swap ? b_idx_i : a_idx_i;
    assign hi_val_o = swap ? a_val_i : b_val_i;
    assign hi_idx_o = swap ? a_idx_i : b_idx_i;
endmodule

// File: rtl/sorter_stream.sv
// rtl/sorter_stream.sv - streaming stable sorter of 4/8/16 metrics with original-index output
// Build option: SORTER_SIGNED_EN (signed metric comparison, inside sorter_cmp_swap).
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start, m  : run request (sampled in IDLE) and mode (00 N=4, 01 N=16, 10 N=8, 11 illegal)
//   s_in      : input beat stream (in_valid / in_ready / d_in)
//   busy      : LOAD or SORT in progress
//   done      : one-cycle pulse, y/idx hold the new result
//   err       : one-cycle pulse for start with the illegal mode
//   y, idx    : sorted metrics (slot 0 smallest) and their original element indices
module sorter_stream
    import sorter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int MAX_N = 16,
    parameter int IDX_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             m,
    sorter_stream_if.slave         s_in,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [MAX_N*WIDTH-1:0] y,
    output logic [MAX_N*IDX_W-1:0] idx
);
    state_t           state_q;
    logic [1:0]       n_sel_q;
    logic [IDX_W-1:0] beat_q;
    logic [IDX_W-1:0] phase_q;
    logic             done_q;
    logic             err_q;

    logic [WIDTH-1:0] val_q [MAX_N];
    logic [IDX_W-1:0] id_q  [MAX_N];
    logic [WIDTH-1:0] val_d [MAX_N];
    logic [IDX_W-1:0] id_d  [MAX_N];
    logic [WIDTH-1:0] y_q   [MAX_N];
    logic [IDX_W-1:0] idx_q [MAX_N];

    logic [WIDTH-1:0] lo_v [MAX_N-1];
    logic [WIDTH-1:0] hi_v [MAX_N-1];
    logic [IDX_W-1:0] lo_i [MAX_N-1];
    logic [IDX_W-1:0] hi_i [MAX_N-1];
    logic             pair_en [MAX_N-1];

    int n_cur;
    int n_req;

    assign n_cur = mode_to_n(n_sel_q);
    assign n_req = mode_to_n(m);

    assign s_in.in_ready = (state_q == LOAD);
    assign busy          = (state_q == LOAD) || (state_q == SORT);
    assign done          = done_q;
    assign err           = err_q;

    // Pair g covers slots (g, g+1): even g on even phases, odd g on odd phases,
    // and only while both slots are inside the active sort length.
    for (genvar g = 0; g < MAX_N - 1; g++) begin : g_pair
        assign pair_en[g] = ((((g % 2) == 1)) == phase_q[0]) && (g + 1 < n_cur);

        sorter_cmp_swap #(
            .WIDTH (WIDTH),
            .IDX_W (IDX_W)
        ) u_cmp_swap (
            .en_i     (pair_en[g]),
            .a_val_i  (val_q[g]),
            .a_idx_i  (id_q[g]),
            .b_val_i  (val_q[g+1]),
            .b_idx_i  (id_q[g+1]),
            .lo_val_o (lo_v[g]),
            .lo_idx_o (lo_i[g]),
            .hi_val_o (hi_v[g]),
            .hi_idx_o (hi_i[g])
        );
    end

    // Pairs of the current parity never overlap, so each slot takes at most one
    // write; disabled pairs pass their inputs through unchanged.
    always_comb begin
        for (int j = 0; j < MAX_N; j++) begin
            val_d[j] = val_q[j];
            id_d[j]  = id_q[j];
        end
        for (int j = 0; j < MAX_N - 1; j++) begin
            if (((j % 2) == 1) == phase_q[0]) begin
                val_d[j]   = lo_v[j];
                id_d[j]    = lo_i[j];
                val_d[j+1] = hi_v[j];
                id_d[j+1]  = hi_i[j];
            end
        end
    end

    for (genvar g = 0; g < MAX_N; g++) begin : g_out
        assign y[g*WIDTH +: WIDTH]   = y_q[g];
        assign idx[g*IDX_W +: IDX_W] = idx_q[g];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_sel_q <= M_QPSK;
            beat_q  <= '0;
            phase_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int j = 0; j < MAX_N; j++) begin
                val_q[j] <= '0;
                id_q[j]  <= '0;
                y_q[j]   <= '0;
                idx_q[j] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (m == M_ILLEGAL) begin
                            err_q <= 1'b1;
                        end else begin
                            n_sel_q <= m;
                            beat_q  <= '0;
                            phase_q <= '0;
                            state_q <= LOAD;
                            // Unused tail slots must read 0 in the result.
                            for (int j = 0; j < MAX_N; j++) begin
                                if (j >= n_req) begin
                                    val_q[j] <= '0;
                                    id_q[j]  <= '0;
                                end
                            end
                        end
                    end
                end
                LOAD: begin
                    if (s_in.in_valid) begin
                        for (int j = 0; j < MAX_N; j++) begin
                            if (j < n_cur && (j / LANES) == int'(beat_q)) begin
                                val_q[j] <= s_in.d_in[(j % LANES)*WIDTH +: WIDTH];
                                id_q[j]  <= IDX_W'(j);
                            end
                        end
                        if (int'(beat_q) == n_cur / LANES - 1) begin
                            state_q <= SORT;
                        end else begin
                            beat_q <= beat_q + IDX_W'(1);
                        end
                    end
                end
                SORT: begin
                    for (int j = 0; j < MAX_N; j++) begin
                        val_q[j] <= val_d[j];
                        id_q[j]  <= id_d[j];
                    end
                    if (int'(phase_q) == n_cur - 1) begin
                        state_q <= DONE;
                    end else begin
                        phase_q <= phase_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    for (int j = 0; j < MAX_N; j++) begin
                        y_q[j]   <= val_q[j];
                        idx_q[j] <= id_q[j];
                    end
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sorter_stream.sv
// tb/tb_sorter_stream.sv - self-checking bench for sorter_stream with a selection-sort reference
module tb_sorter_stream;
    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int MAX_N = 16;
    localparam int IDX_W = 4;
    localparam int BIG   = 1 << 30;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   m = 2'b00;
    logic         busy, done, err;
    logic [127:0] y;
    logic [63:0]  idx;

    sorter_stream_if #(.WIDTH(WIDTH), .LANES(LANES)) sif ();

    sorter_stream #(
        .WIDTH (WIDTH), .LANES (LANES), .MAX_N (MAX_N), .IDX_W (IDX_W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .m     (m),
        .s_in  (sif),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .y     (y),
        .idx   (idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Timeline expectations, written by the driver, read by the compare process.
    int busy_lo = 0, busy_hi = 0, rdy_lo = 0, rdy_hi = 0;
    int done_at = -1, err_at = -1, clear_at = -1;
    int done_cnt = 0, err_cnt = 0, done_seen = -1, last_c0 = 0;
    bit chk_en = 1'b0;
    logic [127:0] exp_y = '0, pend_y = '0;
    logic [63:0]  exp_idx = '0, pend_idx = '0;
    logic [7:0]   vals [16];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endtask

    function automatic bit lt(input logic [7:0] a, input logic [7:0] b);
`ifdef SORTER_SIGNED_EN
        return $signed(a) < $signed(b);
`else
        return a < b;
`endif
    endfunction

    function automatic int model_n(input logic [1:0] mode);
        if (mode == 2'b01) return 16;
        if (mode == 2'b10) return 8;
        return 4;
    endfunction

    // Stable ascending order: repeatedly take the smallest unused value, lowest index on ties.
    task automatic model_sort(input int n);
        bit used [16];
        for (int i = 0; i < 16; i++) used[i] = 1'b0;
        pend_y   = '0;
        pend_idx = '0;
        for (int k = 0; k < n; k++) begin
            int best;
            best = -1;
            for (int i = 0; i < n; i++)
                if (!used[i] && (best < 0 || lt(vals[i], vals[best]))) best = i;
            used[best] = 1'b1;
            pend_y[k*8 +: 8]   = vals[best];
            pend_idx[k*4 +: 4] = 4'(best);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (cyc == clear_at) begin exp_y = '0; exp_idx = '0; end
                if (cyc == done_at) begin exp_y = pend_y; exp_idx = pend_idx; end
                chk("busy", 128'(busy), 128'(cyc >= busy_lo && cyc < busy_hi));
                chk("in_ready", 128'(sif.in_ready), 128'(cyc >= rdy_lo && cyc < rdy_hi));
                chk("done", 128'(done), 128'(cyc == done_at));
                chk("err", 128'(err), 128'(cyc == err_at));
                chk("y", y, exp_y);
                chk("idx", 128'(idx), 128'(exp_idx));
                if (done) begin done_cnt++; done_seen = cyc; end
                if (err) err_cnt++;
            end
        end
    end

    task automatic do_run(input logic [1:0] mode, input bit rnd, input int gap_beat,
                          input int gap_len, input int rst_phase, input int poke_phase);
        int n, s, c0;
        start = 1'b1; m = mode; sif.in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        s = cyc;
        if (mode == 2'b11) begin
            err_at = s;
            @(posedge clk); #1;
            return;
        end
        n = model_n(mode);
        busy_lo = s; busy_hi = BIG; rdy_lo = s; rdy_hi = BIG;
        for (int b = 0; b < n / LANES; b++) begin
            int g;
            g = rnd ? int'($urandom_range(0, 2)) : ((b == gap_beat) ? gap_len : 0);
            for (int k = 0; k < g; k++) begin
                sif.in_valid = 1'b0; sif.d_in = $urandom;
                start = rnd ? 1'($urandom_range(0, 1)) : 1'b0; m = 2'($urandom);
                @(posedge clk); #1;
            end
            start = 1'b0;
            sif.in_valid = 1'b1;
            for (int l = 0; l < LANES; l++) sif.d_in[l*WIDTH +: WIDTH] = vals[b*LANES + l];
            @(posedge clk); #1;
        end
        sif.in_valid = 1'b0;
        c0 = cyc; last_c0 = c0;
        rdy_hi = c0;
        busy_hi = c0 + n;
        model_sort(n);
        if (rst_phase >= 0) begin
            while (cyc < c0 + rst_phase) begin @(posedge clk); #1; end
            rst = 1'b1;
            busy_hi = cyc + 1; clear_at = cyc + 1;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        done_at = c0 + n + 1;
        while (cyc <= done_at) begin
            start = (cyc == c0 + poke_phase) ||
                    (rnd && cyc <= c0 + n && $urandom_range(0, 3) == 0);
            m = 2'($urandom);
            sif.in_valid = rnd ? 1'($urandom) : 1'b0;
            sif.d_in = $urandom;
            @(posedge clk); #1;
        end
        start = 1'b0; sif.in_valid = 1'b0;
    endtask

    initial begin
        logic [127:0] lit;
        int qam_exp [16] = '{0, 1, 5, 6, 7, 8, 9, 10, 10, 11, 12, 20, 47, 48, 49, 50};
        int qam_in  [16] = '{10, 20, 1, 0, 9, 10, 11, 12, 5, 6, 7, 8, 47, 48, 49, 50};
        int d0, e0;

        sif.in_valid = 1'b0; sif.d_in = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_y", y, '0);
        chk("reset_busy", 128'(busy), '0);
        chk("reset_done_err", 128'({done, err}), '0);
        chk_en = 1'b1;

        // QPSK single beat
        vals[0] = 8'd10; vals[1] = 8'd20; vals[2] = 8'd1; vals[3] = 8'd0;
        do_run(2'b00, 1'b0, -1, 0, -1, -1);
        chk("qpsk_y", y, 128'h140A0100);
        chk("qpsk_idx", 128'(idx), 128'h1023);
        chk("qpsk_latency", 128'(done_seen - last_c0), 128'd5);

        // QAM16 with a 2-cycle gap after the first beat
        for (int i = 0; i < 16; i++) vals[i] = 8'(qam_in[i]);
        do_run(2'b01, 1'b0, 1, 2, -1, -1);
        lit = '0;
        for (int k = 0; k < 16; k++) lit[k*8 +: 8] = 8'(qam_exp[k]);
        chk("qam16_y", y, lit);
        chk("qam16_tie_idx", 128'({idx[35:32], idx[31:28]}), 128'h50);

        // illegal mode, then a legal QPSK run
        e0 = err_cnt; d0 = done_cnt;
        do_run(2'b11, 1'b0, -1, 0, -1, -1);
        chk("err_pulses", 128'(err_cnt - e0), 128'd1);
        chk("err_no_done", 128'(done_cnt - d0), 128'd0);
        for (int i = 0; i < 16; i++) vals[i] = 8'($urandom);
        do_run(2'b00, 1'b0, -1, 0, -1, -1);

        // start poked during SORT of an 8-element run
        for (int i = 0; i < 16; i++) vals[i] = 8'($urandom_range(0, 7));
        d0 = done_cnt;
        do_run(2'b10, 1'b0, -1, 0, -1, 3);
        chk("poke_single_done", 128'(done_cnt - d0), 128'd1);

        // reset on SORT phase 3
        for (int i = 0; i < 16; i++) vals[i] = 8'($urandom);
        d0 = done_cnt;
        do_run(2'b01, 1'b0, -1, 0, 3, -1);
        chk("rst_y", y, '0);
        chk("rst_busy", 128'(busy), '0);
        @(posedge clk); #1;
        chk("rst_no_done", 128'(done_cnt - d0), 128'd0);
        for (int i = 0; i < 16; i++) vals[i] = 8'($urandom);
        do_run(2'b00, 1'b0, -1, 0, -1, -1);

        // signed/unsigned ordering corner
        vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h7F; vals[3] = 8'h80;
        do_run(2'b00, 1'b0, -1, 0, -1, -1);
`ifdef SORTER_SIGNED_EN
        chk("signed_y", y, 128'h7F00FF80);
`else
        chk("unsigned_y", y, 128'hFF807F00);
`endif

        // randomized runs
        for (int r = 0; r < 40; r++) begin
            logic [1:0] mode;
            mode = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            for (int i = 0; i < 16; i++)
                vals[i] = (r % 2 == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin
                sif.in_valid = 1'($urandom); sif.d_in = $urandom;
                @(posedge clk); #1;
            end
            do_run(mode, 1'b1, -1, 0, -1, -1);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end
endmodule
